isqrt_iter: RTL

Iterative 32-bit integer square root responder: accepts an operand on a valid-only strobe and returns floor(sqrt(x)) on a one-cycle valid pulse. It is the server end of the `isqrt_N_x_vld`/`isqrt_N_x`/`isqrt_N_y_vld`/`isqrt_N_y` interface driven by the formula FSMs. One instance sits behind each isqrt port of those FSMs. The interface has no backpressure, so a small request FIFO absorbs operands that arrive while a computation is in progress.

---
 rtl/isqrt_pkg.sv | 14 +
 rtl/isqrt_req_fifo.sv | 52 +++++
 rtl/isqrt_iter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and widths for the iterative integer square root responder.
package isqrt_pkg;

  localparam int unsigned ISQRT_X_W   = 32;
  localparam int unsigned ISQRT_Y_W   = 16;
  localparam int unsigned ISQRT_ITERS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } isqrt_state_t;

endpackage

// File: rtl/isqrt_req_fifo.sv
// Request queue for pending square-root operands.
// Power-of-two depth, with an extra pointer bit to tell full from empty.
module isqrt_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push onto a full queue still lands.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/isqrt_iter.sv
// Iterative 32-bit floor(sqrt(x)) responder: one result bit per CALC cycle.
// Define ISQRT_ITER_EARLY_EXIT_EN to halve latency for operands below 2^16.
module isqrt_iter
  import isqrt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_vld,
  input  logic [ISQRT_X_W-1:0] x,
  output logic                 y_vld,
  output logic [ISQRT_Y_W-1:0] y,
  output logic                 busy,
  output logic                 ovf
);

  isqrt_state_t         r_state;
  isqrt_state_t         w_state_nxt;

  logic [31:0]          r_op;
  logic [17:0]          r_rem;
  logic [15:0]          r_root;
  logic [4:0]           r_cnt;
  logic [15:0]          r_y;
  logic                 r_busy;
  logic                 r_ovf;

  logic                 w_load;
  logic                 w_push;
  logic                 w_pop;
  logic [31:0]          w_ld_data;
  logic [31:0]          w_ld_op;
  logic [4:0]           w_ld_cnt;
  logic [31:0]          w_fifo_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  logic [17:0]          w_t;
  logic [17:0]          w_trial;
  logic [17:0]          w_rem_nxt;
  logic [15:0]          w_root_nxt;

  isqrt_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ISQRT_X_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (x),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (x_vld) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_push = x_vld;
        if (r_cnt == 5'd1) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Queued work has priority; a fresh operand then joins the queue behind it.
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_push      = x_vld;
          w_state_nxt = CALC;
        end else if (x_vld) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_ld_data = w_pop ? w_fifo_head : x;

  always_comb begin
    w_ld_op  = w_ld_data;
    w_ld_cnt = 5'(ISQRT_ITERS);
`ifdef ISQRT_ITER_EARLY_EXIT_EN
    // Upper half zero: the first eight result bits are zero, so skip them.
    if (w_ld_data[31:16] == '0) begin
      w_ld_op  = {w_ld_data[15:0], 16'h0000};
      w_ld_cnt = 5'(ISQRT_ITERS / 2);
    end
`endif
  end

  assign w_t     = {r_rem[15:0], r_op[31:30]};
  assign w_trial = {r_root, 2'b01};

  always_comb begin
    w_rem_nxt  = w_t;
    w_root_nxt = {r_root[14:0], 1'b0};
    if (w_t >= w_trial) begin
      w_rem_nxt  = w_t - w_trial;
      w_root_nxt = {r_root[14:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_push && w_fifo_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op   <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
    end else if (w_load) begin
      r_op   <= w_ld_op;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= w_ld_cnt;
    end else if (r_state == CALC) begin
      r_op   <= {r_op[29:0], 2'b00};
      r_rem  <= w_rem_nxt;
      r_root <= w_root_nxt;
      r_cnt  <= r_cnt - 5'd1;
      // Captured separately so y survives the next operand's load.
      if (r_cnt == 5'd1) begin
        r_y <= w_root_nxt;
      end
    end
  end

  assign y_vld = (r_state == DONE);
  assign y     = r_y;
  assign busy  = r_busy;
  assign ovf   = r_ovf;

endmodule
